// File: rtl/axi_master_pkg.sv
// Shared types and AXI encodings for the FFT-side AXI burst master.
// Holds the controller state encoding and the legal run-length check.
package axi_master_pkg;

  typedef enum logic [2:0] {
    master_IDLE      = 3'd0,
    master_AW        = 3'd1,
    master_W         = 3'd2,
    master_B         = 3'd3,
    master_WAIT_CALC = 3'd4,
    master_AR        = 3'd5,
    master_R         = 3'd6,
    master_DONE      = 3'd7
  } master_fsm;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_16    = 3'b001;
  localparam logic [2:0] AXI_SIZE_32    = 3'b010;
  localparam int unsigned MAX_BEATS     = 256;

  // A run is legal for 1..MAX_BEATS beats (one INCR burst of at most 256 beats)
  function automatic logic beats_legal(input logic [11:0] n);
    return (n != 12'd0) && (n <= 12'(MAX_BEATS));
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beat index counter for one AXI burst; i_length carries AXI LEN (beats - 1).
// o_last flags the final beat so the owner can raise LAST or stop the burst.
module axi_beat_counter
  import axi_master_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [7:0] i_length,
  output logic [7:0] o_count,
  output logic       o_last
);

  logic [7:0] count_r;

  // Beat index, advances once per accepted handshake
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_r <= 8'd0;
    end else if (i_clear) begin
      count_r <= 8'd0;
    end else if (i_enable) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign o_count = count_r;
  assign o_last  = (count_r == i_length);

endmodule

// File: rtl/axi_fft_master.sv
// AXI4 master feeding the FFT bridge: one INCR write burst of samples, then
// after the calculation completes one INCR read burst of results into a sink.
module axi_fft_master
  import axi_master_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_W_WIDTH = 2,
  parameter int ID_R_WIDTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_START,
  input  logic [11:0]           i_SAMPLES_NUMBER,
  input  logic [11:0]           i_BASE_ADDR,
  input  logic [ID_W_WIDTH-1:0] i_TRANS_ID,
  output logic [11:0]           o_SRC_INDEX,
  input  logic [15:0]           i_SRC_DATA,
  input  logic                  i_CALC_END,
  output logic                  o_RES_WRITE,
  output logic [11:0]           o_RES_INDEX,
  output logic [DATA_WIDTH-1:0] o_RES_DATA,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_ERROR,
  output logic [11:0]           o_AWADDR,
  output logic [7:0]            o_AWLEN,
  output logic [2:0]            o_AWSIZE,
  output logic [1:0]            o_AWBURST,
  output logic [ID_W_WIDTH-1:0] o_AWID,
  output logic                  o_AWVALID,
  input  logic                  i_AWREADY,
  output logic [15:0]           o_WDATA,
  output logic [1:0]            o_WSTRB,
  output logic                  o_WVALID,
  output logic                  o_WLAST,
  input  logic                  i_WREADY,
  input  logic                  i_BVALID,
  input  logic [ID_W_WIDTH-1:0] i_BID,
  output logic                  o_BREADY,
  output logic [11:0]           o_ARADDR,
  output logic [7:0]            o_ARLEN,
  output logic [2:0]            o_ARSIZE,
  output logic [1:0]            o_ARBURST,
  output logic [ID_R_WIDTH-1:0] o_ARID,
  output logic                  o_ARVALID,
  input  logic                  i_ARREADY,
  input  logic [DATA_WIDTH-1:0] i_RDATA,
  input  logic [ID_R_WIDTH-1:0] i_RID,
  input  logic                  i_RVALID,
  input  logic                  i_RLAST,
  output logic                  o_RREADY
);

  master_fsm             state_r;
  logic [7:0]            len_m1_r;
  logic [11:0]           base_r;
  logic [ID_W_WIDTH-1:0] id_r;
  logic                  error_r;
  logic                  calc_seen_r;
  logic                  res_write_r;
  logic [11:0]           res_index_r;
  logic [DATA_WIDTH-1:0] res_data_r;

  logic [7:0] wcnt_s, rcnt_s;
  logic       wlast_s, rlast_s, w_hs_s, r_hs_s, cnt_clear_s, rid_bad_s, calc_window_s;

  assign w_hs_s        = (state_r == master_W) && i_WREADY;
  assign r_hs_s        = (state_r == master_R) && i_RVALID;
  assign cnt_clear_s   = (state_r == master_IDLE);
  assign rid_bad_s     = (i_RID != ID_R_WIDTH'(id_r));
  assign calc_window_s = (state_r == master_W) || (state_r == master_B) ||
                         (state_r == master_WAIT_CALC);

  axi_beat_counter u_wcnt (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(cnt_clear_s), .i_enable(w_hs_s),
    .i_length(len_m1_r), .o_count(wcnt_s), .o_last(wlast_s)
  );

  axi_beat_counter u_rcnt (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(cnt_clear_s), .i_enable(r_hs_s),
    .i_length(len_m1_r), .o_count(rcnt_s), .o_last(rlast_s)
  );

  // Run sequencer: bursts, response checks, calc-end latch and result-sink writes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= master_IDLE;
      len_m1_r    <= 8'd0;
      base_r      <= 12'd0;
      id_r        <= '0;
      error_r     <= 1'b0;
      calc_seen_r <= 1'b0;
      res_write_r <= 1'b0;
      res_index_r <= 12'd0;
      res_data_r  <= '0;
    end else begin
      res_write_r <= 1'b0;
      if (i_CALC_END && calc_window_s) begin
        calc_seen_r <= 1'b1;
      end
      case (state_r)
        master_IDLE: begin
          if (i_START) begin
            if (beats_legal(i_SAMPLES_NUMBER)) begin
              len_m1_r    <= 8'(i_SAMPLES_NUMBER - 12'd1);
              base_r      <= i_BASE_ADDR;
              id_r        <= i_TRANS_ID;
              error_r     <= 1'b0;
              calc_seen_r <= 1'b0;
              state_r     <= master_AW;
            end else begin
              // Illegal length: report and finish without touching the bus
              error_r <= 1'b1;
              state_r <= master_DONE;
            end
          end
        end
        master_AW: if (i_AWREADY) state_r <= master_W;
        master_W:  if (i_WREADY && wlast_s) state_r <= master_B;
        master_B: begin
          if (i_BVALID) begin
            if (i_BID != id_r) error_r <= 1'b1;
            state_r <= master_WAIT_CALC;
          end
        end
        master_WAIT_CALC: if (calc_seen_r) state_r <= master_AR;
        master_AR: if (i_ARREADY) state_r <= master_R;
        master_R: begin
          if (i_RVALID) begin
            res_write_r <= 1'b1;
            res_index_r <= {4'd0, rcnt_s};
            res_data_r  <= i_RDATA;
            if ((i_RLAST != rlast_s) || rid_bad_s) error_r <= 1'b1;
            // An early RLAST ends the burst as the slave sees it
            if (rlast_s || i_RLAST) state_r <= master_DONE;
          end
        end
        master_DONE: state_r <= master_IDLE;
        default:     state_r <= master_IDLE;
      endcase
    end
  end

  assign o_AWVALID   = (state_r == master_AW);
  assign o_AWADDR    = base_r;
  assign o_AWLEN     = len_m1_r;
  assign o_AWSIZE    = AXI_SIZE_16;
  assign o_AWBURST   = AXI_BURST_INCR;
  assign o_AWID      = id_r;
  assign o_WVALID    = (state_r == master_W);
  assign o_SRC_INDEX = {4'd0, wcnt_s};
  assign o_WDATA     = i_SRC_DATA;
  assign o_WSTRB     = 2'b11;
  assign o_WLAST     = (state_r == master_W) && wlast_s;
  assign o_BREADY    = (state_r == master_B);
  assign o_ARVALID   = (state_r == master_AR);
  assign o_ARADDR    = base_r;
  assign o_ARLEN     = len_m1_r;
  assign o_ARSIZE    = AXI_SIZE_32;
  assign o_ARBURST   = AXI_BURST_INCR;
  assign o_ARID      = ID_R_WIDTH'(id_r);
  assign o_RREADY    = (state_r == master_R);
  assign o_RES_WRITE = res_write_r;
  assign o_RES_INDEX = res_index_r;
  assign o_RES_DATA  = res_data_r;
  assign o_BUSY      = (state_r != master_IDLE);
  assign o_DONE      = (state_r == master_DONE);
  assign o_ERROR     = error_r;

endmodule

// File: tb/tb_axi_fft_master.sv
// Directed bench for axi_fft_master: a table of runs against a scripted AXI
// slave, plus hand sequences for reset behaviour.
module tb_axi_fft_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] samples_number, base_addr;
  logic [1:0]  trans_id;
  logic [11:0] src_index;
  logic [15:0] src_data;
  logic        calc_end;
  logic        res_write;
  logic [11:0] res_index;
  logic [31:0] res_data;
  logic        busy, done, error;
  logic [11:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, awid, arid, bid, rid;
  logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic [15:0] wdata;
  logic [1:0]  wstrb;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_errors = 0;
  int cur_vec  = -1;

  always #5 clk = ~clk;

  // Sample source: each index maps to a distinct known value
  assign src_data = 16'hA000 + {4'd0, src_index};

  axi_fft_master dut (
    .i_clk(clk), .i_rst(rst), .i_START(start), .i_SAMPLES_NUMBER(samples_number),
    .i_BASE_ADDR(base_addr), .i_TRANS_ID(trans_id), .o_SRC_INDEX(src_index),
    .i_SRC_DATA(src_data), .i_CALC_END(calc_end), .o_RES_WRITE(res_write),
    .o_RES_INDEX(res_index), .o_RES_DATA(res_data), .o_BUSY(busy), .o_DONE(done),
    .o_ERROR(error), .o_AWADDR(awaddr), .o_AWLEN(awlen), .o_AWSIZE(awsize),
    .o_AWBURST(awburst), .o_AWID(awid), .o_AWVALID(awvalid), .i_AWREADY(awready),
    .o_WDATA(wdata), .o_WSTRB(wstrb), .o_WVALID(wvalid), .o_WLAST(wlast),
    .i_WREADY(wready), .i_BVALID(bvalid), .i_BID(bid), .o_BREADY(bready),
    .o_ARADDR(araddr), .o_ARLEN(arlen), .o_ARSIZE(arsize), .o_ARBURST(arburst),
    .o_ARID(arid), .o_ARVALID(arvalid), .i_ARREADY(arready), .i_RDATA(rdata),
    .i_RID(rid), .i_RVALID(rvalid), .i_RLAST(rlast), .o_RREADY(rready)
  );

  typedef struct {
    int n; int base; int id; int stall; int aw_delay; int bid; int rid;
    int rlast_at; int calc_mode; int restart; int exp_err; int exp_writes;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", name, cur_vec, got, exp);
    end
  endtask

  function automatic logic [8:0] active_vec();
    return {busy, done, error, awvalid, wvalid, bready, arvalid, rready, res_write};
  endfunction

  task automatic idle_slave();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 2'd0; arready = 1'b0;
    rvalid = 1'b0; rdata = 32'd0; rid = 2'd0; rlast = 1'b0; calc_end = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc = 0, wbeats = 0, rbeats = 0, writes = 0;
    int aw_cyc = -1, b_cyc = -1, ar_cyc = -1, done_cyc = -1, last_r_cyc = -1, calc_cyc = -1;
    bit done_seen = 0, any_valid = 0, calc_sent = 0, stall_pend = 0, legal, cal, busy1 = 0;
    logic [15:0] stall_data = 16'd0;
    legal = (v.n >= 1) && (v.n <= 256);
    @(posedge clk); #1;
    start = 1'b1; samples_number = 12'(v.n); base_addr = 12'(v.base); trans_id = 2'(v.id);
    while (!done_seen && cyc < 3000) begin
      @(posedge clk); cyc++; #1;
      start = (v.restart != 0) && (cyc == 20);
      samples_number = start ? 12'd2 : 12'(v.n);
      awready = (cyc >= v.aw_delay);
      wready  = (v.stall != 0) ? (cyc % 2 == 1) : 1'b1;
      bvalid  = bready && (b_cyc < 0);
      bid     = 2'(v.bid);
      arready = 1'b1;
      case (v.calc_mode)
        0: cal = (wbeats >= 1) && !calc_sent;
        1: cal = (b_cyc >= 0) && (cyc == b_cyc + 50);
        default: cal = (cyc == 2) || ((b_cyc >= 0) && (cyc == b_cyc + 10));
      endcase
      if (cal) begin calc_sent = 1; calc_cyc = cyc; end
      calc_end = cal;
      rvalid = rready && ((v.stall != 0) ? (cyc % 2 == 0) : 1'b1);
      rdata  = 32'hC0DE_0000 | 32'(rbeats);
      rlast  = (rbeats == v.rlast_at);
      rid    = 2'(v.rid);
      @(negedge clk);
      if (cyc == 1) busy1 = busy;
      if (awvalid || wvalid || bready || arvalid || rready) any_valid = 1;
      if (awvalid && aw_cyc < 0) aw_cyc = cyc;
      if (awvalid && awready) begin
        chk("awaddr", awaddr, v.base); chk("awlen", awlen, (v.n - 1) & 255);
        chk("awsize", awsize, 3'b001); chk("awburst", awburst, 2'b01); chk("awid", awid, v.id);
      end
      if (stall_pend && wvalid) chk("w_stable", wdata, stall_data);
      stall_pend = wvalid && !wready;
      stall_data = wdata;
      if (wvalid && wready) begin
        chk("w_index", src_index, wbeats);
        chk("wdata", wdata, 16'hA000 + 16'(wbeats));
        chk("wlast", wlast, wbeats == v.n - 1);
        chk("wstrb", wstrb, 2'b11);
        wbeats++;
      end
      if (bready && bvalid) b_cyc = cyc;
      if (arvalid && ar_cyc < 0) ar_cyc = cyc;
      if (arvalid && arready) begin
        chk("araddr", araddr, v.base); chk("arlen", arlen, (v.n - 1) & 255);
        chk("arsize", arsize, 3'b010); chk("arburst", arburst, 2'b01); chk("arid", arid, v.id);
      end
      if (rready && rvalid) begin last_r_cyc = cyc; rbeats++; end
      if (res_write) begin
        chk("res_index", res_index, writes);
        chk("res_data", res_data, 32'hC0DE_0000 | 32'(writes));
        writes++;
      end
      if (done) begin done_seen = 1; done_cyc = cyc; chk("error", error, v.exp_err); end
    end
    chk("done_seen", done_seen, 1'b1);
    chk("sink_writes", writes, v.exp_writes);
    chk("busy_after_start", busy1, 1'b1);
    if (legal) begin
      chk("aw_latency", aw_cyc, 1);
      chk("w_beats", wbeats, v.n);
      chk("done_after_last_r", done_cyc, last_r_cyc + 1);
      chk("ar_after_calc", ar_cyc > calc_cyc, 1'b1);
      chk("ar_after_b", (b_cyc >= 0) && (ar_cyc > b_cyc), 1'b1);
    end else begin
      chk("illegal_done_latency", done_cyc, 1);
      chk("illegal_no_valid", any_valid, 1'b0);
    end
    idle_slave();
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("done_pulse", done, 1'b0);
    chk("error_sticky", error, v.exp_err);
  endtask

  initial begin
    bit found;
    //        n    base   id st awd bid rid rlast mode rst err wr
    vecs[0]  = '{4,   'h000, 1, 0, 0, 1, 1, 3,    0, 0, 0, 4};
    vecs[1]  = '{8,   'h100, 2, 1, 0, 2, 2, 7,    0, 0, 0, 8};
    vecs[2]  = '{4,   'h020, 1, 0, 0, 1, 1, 3,    1, 1, 0, 4};
    vecs[3]  = '{4,   'h000, 1, 0, 0, 1, 1, 2,    0, 0, 1, 3};
    vecs[4]  = '{4,   'h000, 1, 0, 0, 2, 1, 3,    0, 0, 1, 4};
    vecs[5]  = '{1,   'hFFE, 3, 0, 4, 3, 3, 0,    2, 0, 0, 1};
    vecs[6]  = '{0,   'h000, 1, 0, 0, 1, 1, 0,    0, 0, 1, 0};
    vecs[7]  = '{300, 'h000, 1, 0, 0, 1, 1, 0,    0, 0, 1, 0};
    vecs[8]  = '{256, 'h200, 0, 0, 0, 0, 0, 255,  0, 0, 0, 256};
    vecs[9]  = '{4,   'h010, 2, 0, 0, 2, 2, 1000, 0, 0, 1, 4};
    vecs[10] = '{5,   'h010, 2, 0, 0, 2, 1, 4,    0, 0, 1, 5};

    rst = 1'b1; start = 1'b0; samples_number = 12'd0; base_addr = 12'd0; trans_id = 2'd0;
    idle_slave();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", active_vec(), 9'd0);
    rst = 1'b0;

    // Reset while the third W beat is on the bus
    @(posedge clk); #1;
    start = 1'b1; samples_number = 12'd8; base_addr = 12'h040; trans_id = 2'd1;
    awready = 1'b1; wready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (wvalid && src_index == 12'd2) found = 1;
    end
    chk("rst_reach_w3", found, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_slave();
    @(negedge clk);
    chk("rst_mid_outputs", active_vec(), 9'd0);
    chk("rst_mid_src_index", src_index, 12'd0);

    for (int i = 0; i < 11; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
